mc_ctrl: RTL

Multicycle control unit for the MIPS core, directly downstream of the instruction fetch unit. It consumes the 32-bit instruction word the fetch unit presents and the ALU zero flag. It sequences each instruction through a Moore state machine, driving the fetch unit's PC controls (PCWr, nPC_sel, j_sel) and the datapath's register-file, ALU, extender and memory controls. It also counts retired instructions and flags unsupported opcodes.

---
 rtl/mc_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: captures opcode/funct in FETCH and sequences
// Moore controls; 2-5 cycles per instruction, no backpressure (free-running).
module mc_ctrl #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instruction,
    input  logic               zero,
    output logic               PCWr,
    output logic [1:0]         nPC_sel,
    output logic               j_sel,
    output logic               IRWr,
    output logic               RegWr,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         ExtOp,
    output logic               ALUSrc,
    output logic [2:0]         ALUOp,
    output logic               MemWr,
    output logic [STATE_W-1:0] state,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_EXE    = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_WBA    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MA     = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MR     = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_WBM    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_MW     = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BR     = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JMP    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JR     = STATE_W'(10);

    logic [5:0]         op_q;
    logic [5:0]         fn_q;
    logic [STATE_W-1:0] next_state;
    logic               retire;
    logic               unused_bits;

    assign unused_bits = ^instruction[25:6];

    // Decoding runs off the captured copy; the fetch word moves once PC advances.
    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    assign is_r    = (op_q == 6'b000000);
    assign is_addu = is_r && (fn_q == 6'b100001);
    assign is_subu = is_r && (fn_q == 6'b100011);
    assign is_jr   = is_r && (fn_q == 6'b001000);
    assign is_ori  = (op_q == 6'b001101);
    assign is_lui  = (op_q == 6'b001111);
    assign is_lw   = (op_q == 6'b100011);
    assign is_sw   = (op_q == 6'b101011);
    assign is_beq  = (op_q == 6'b000100);
    assign is_j    = (op_q == 6'b000010);
    assign is_jal  = (op_q == 6'b000011);

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (is_addu || is_subu || is_ori || is_lui) next_state = S_EXE;
                else if (is_lw || is_sw)                    next_state = S_MA;
                else if (is_beq)                            next_state = S_BR;
                else if (is_j || is_jal)                    next_state = S_JMP;
                else if (is_jr)                             next_state = S_JR;
                else                                        next_state = S_FETCH;
            end
            S_EXE:    next_state = S_WBA;
            S_MA:     next_state = is_lw ? S_MR : S_MW;
            S_MR:     next_state = S_WBM;
            default:  next_state = S_FETCH;
        endcase
    end

    assign retire = (state == S_WBA) || (state == S_WBM) || (state == S_MW) ||
                    (state == S_BR)  || (state == S_JMP) || (state == S_JR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH) begin
                op_q <= instruction[31:26];
                fn_q <= instruction[5:0];
            end
            if (state == S_DECODE && next_state == S_FETCH) illegal <= 1'b1;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        PCWr     = 1'b0;
        nPC_sel  = 2'b00;
        j_sel    = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        ExtOp    = 2'b00;
        ALUSrc   = 1'b0;
        ALUOp    = 3'b000;
        MemWr    = 1'b0;
        case (state)
            S_FETCH: begin
                IRWr = 1'b1;
                PCWr = 1'b1;
            end
            S_EXE, S_WBA: begin
                if (is_subu)     ALUOp = 3'b001;
                else if (is_ori) ALUOp = 3'b010;
                ALUSrc = is_ori || is_lui;
                ExtOp  = is_lui ? 2'b10 : 2'b00;
                if (state == S_WBA) begin
                    RegWr  = 1'b1;
                    RegDst = is_r ? 2'b01 : 2'b00;
                end
            end
            S_MA, S_MR, S_MW: begin
                ALUSrc = 1'b1;
                ExtOp  = 2'b01;
                MemWr  = (state == S_MW);
            end
            S_WBM: begin
                RegWr    = 1'b1;
                MemtoReg = 2'b01;
            end
            S_BR: begin
                ALUOp   = 3'b001;
                nPC_sel = 2'b01;
                PCWr    = zero;
            end
            S_JMP: begin
                PCWr  = 1'b1;
                j_sel = 1'b1;
                if (is_jal) begin
                    RegWr    = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
            end
            S_JR: begin
                PCWr    = 1'b1;
                nPC_sel = 2'b11;
            end
            default: ;
        endcase
    end

endmodule
